// File: rtl/stream_demux_pkg.sv
// Shared constants for the 1-to-N stream demultiplexer.
package stream_demux_pkg;
  localparam int MODE_SEL   = 0;
  localparam int MODE_RR    = 1;
  localparam int DROP_CNT_W = 8;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // NOTE: non-blocking assignments in clocked blocks keep every register
  // sampling the pre-edge value, so block order never changes behaviour.
  // NOTE: the data register is reset too because the output bus must read
  // zero after reset, not just be flagged invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      // A load while draining refills in place, giving one beat per cycle.
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/stream_demux_n.sv
// 1-to-N valid/ready demultiplexer: explicit-select or round-robin routing,
// one holding register per output, invalid selects dropped and counted.
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = $clog2(N_OUT),
  parameter int MODE   = MODE_SEL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    err_sel,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);
  logic [SEL_W-1:0]      tgt;
  logic                  tgt_ok;
  logic                  sel_ready;
  logic                  accept;
  logic                  drop;
  logic [N_OUT-1:0]      load;
  logic [SEL_W-1:0]      rr_q, rr_d;
  logic                  err_q;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    tgt       = (MODE == MODE_RR) ? rr_q : in_sel;
    tgt_ok    = (int'(tgt) < N_OUT);
    // Default 1 covers the drop path: an out-of-range target matches no slot.
    sel_ready = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      if (tgt == SEL_W'(k)) sel_ready = !out_valid[k] | out_ready[k];
    end
  end

  assign in_ready = sel_ready;
  assign accept   = in_valid & sel_ready;
  assign drop     = accept & !tgt_ok;

  always_comb begin
    rr_d = rr_q;
    if (accept && (MODE == MODE_RR)) begin
      rr_d = (rr_q == SEL_W'(N_OUT - 1)) ? '0 : rr_q + 1'b1;
    end
    drop_d = (drop && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q   <= '0;
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      rr_q   <= rr_d;
      err_q  <= drop;
      drop_q <= drop_d;
    end
  end

  assign err_sel  = err_q;
  assign drop_cnt = drop_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign load[k] = accept & (tgt == SEL_W'(k));

    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[k]),
      .data_i  (in_data),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (out_data[k*DATA_W +: DATA_W])
    );
  end
endmodule
